// File: rtl/mem_responder.sv
// Single-port word memory answering instruction fetches and data accesses after a fixed latency.
// Optional build macro MEM_RESP_MISALIGN_CHK_EN flags and suppresses misaligned accesses.
module mem_responder #(
  parameter int ADDR_W = 10,
  parameter int LAT    = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemRen,
  input  logic [31:0] imemaddr,
  output logic [31:0] imemload,
  output logic        iready,
  input  logic        dmmRen,
  input  logic        dmmWen,
  input  logic [31:0] dmmaddr,
  input  logic [31:0] dmmstore,
  output logic [31:0] dmmload,
  output logic        dready,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        r_state;
  logic [2:0]        r_cnt;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_wr;
  logic              r_dat;
  logic [31:0]       r_imemload, r_dmmload;
  logic              r_iready, r_dready, r_err;
  logic [31:0]       r_mem [0:DEPTH-1];

  logic              w_dreq, w_fire, w_mis, w_wen;
  logic [ADDR_W-1:0] w_idx;
  logic              w_unused;

  assign w_dreq = dmmRen | dmmWen;
  // The last WAIT edge is the RESP-entry edge: array access and ready happen here.
  assign w_fire = (r_state == WAIT) && (r_cnt == 3'd0);
  assign w_idx  = r_addr[ADDR_W+1:2];

`ifdef MEM_RESP_MISALIGN_CHK_EN
  assign w_mis    = (r_addr[1:0] != 2'b00);
  assign w_unused = &{1'b0, imemaddr[31:ADDR_W+2], dmmaddr[31:ADDR_W+2]};
`else
  assign w_mis    = 1'b0;
  assign w_unused = &{1'b0, imemaddr[31:ADDR_W+2], dmmaddr[31:ADDR_W+2], r_addr[1:0]};
`endif

  // Gating on nRST lets a reset on the RESP-entry edge abort the write.
  assign w_wen = nRST && w_fire && r_wr && !w_mis;

  always_ff @(posedge CLK) begin
    if (w_wen) r_mem[w_idx] <= r_wdata;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_cnt      <= 3'd0;
      r_iready   <= 1'b0;
      r_dready   <= 1'b0;
      r_err      <= 1'b0;
      r_imemload <= 32'd0;
      r_dmmload  <= 32'd0;
    end else begin
      r_iready <= 1'b0;
      r_dready <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_dreq || imemRen) begin
            r_state <= WAIT;
            r_cnt   <= 3'(LAT - 1);
            r_dat   <= w_dreq;
            r_wr    <= dmmWen;
            r_addr  <= w_dreq ? dmmaddr[ADDR_W+1:0] : imemaddr[ADDR_W+1:0];
            r_wdata <= dmmstore;
          end
        end
        WAIT: begin
          if (r_cnt == 3'd0) begin
            r_state <= RESP;
            r_err   <= w_mis;
            if (r_dat) r_dready <= 1'b1;
            else       r_iready <= 1'b1;
            if (!r_wr) begin
              if (r_dat) r_dmmload  <= w_mis ? 32'd0 : r_mem[w_idx];
              else       r_imemload <= w_mis ? 32'd0 : r_mem[w_idx];
            end
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign imemload = r_imemload;
  assign dmmload  = r_dmmload;
  assign iready   = r_iready;
  assign dready   = r_dready;
  assign err      = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (LAT=2, ADDR_W=10); inputs change and outputs are sampled on negedges.
module tb_mem_responder;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemRen;
  logic [31:0] imemaddr;
  logic [31:0] imemload;
  logic        iready;
  logic        dmmRen;
  logic        dmmWen;
  logic [31:0] dmmaddr;
  logic [31:0] dmmstore;
  logic [31:0] dmmload;
  logic        dready;
  logic        err;

  int checks = 0;
  int errors = 0;

  mem_responder #(.ADDR_W(10), .LAT(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .imemRen(imemRen), .imemaddr(imemaddr), .imemload(imemload), .iready(iready),
    .dmmRen(dmmRen), .dmmWen(dmmWen), .dmmaddr(dmmaddr), .dmmstore(dmmstore),
    .dmmload(dmmload), .dready(dready), .err(err)
  );

  always #5 CLK = ~CLK;

  // Issue one request and wait (bounded) for its ready; lat counts negedges after the
  // acceptance edge, so LAT=2 should give 2. lat stays -1 on timeout.
  task automatic xfer(input logic ir, input logic dr, input logic dw, input logic [31:0] a,
                      input logic [31:0] d, output int lat, output logic [31:0] ld,
                      output logic er, output logic was_d);
    @(negedge CLK);
    imemRen = ir; dmmRen = dr; dmmWen = dw;
    imemaddr = a; dmmaddr = a; dmmstore = d;
    @(negedge CLK);
    imemRen = 1'b0; dmmRen = 1'b0; dmmWen = 1'b0;
    lat = -1; ld = 32'hx; er = 1'bx; was_d = 1'bx;
    for (int i = 0; i < 20; i++) begin
      if (iready || dready) begin
        lat = i; was_d = dready; er = err;
        ld = dready ? dmmload : imemload;
        break;
      end
      @(negedge CLK);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    nRST = 1'b0; imemRen = 1'b0; dmmRen = 1'b0; dmmWen = 1'b0;
    imemaddr = 32'd0; dmmaddr = 32'd0; dmmstore = 32'd0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({iready, dready, err} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes got %b want 000", {iready, dready, err});
    end
    checks++;
    if (imemload !== 32'd0 || dmmload !== 32'd0) begin
      errors++; $display("FAIL reset_loads got %h/%h want 0/0", imemload, dmmload);
    end
    nRST = 1'b1;
  endtask

  task automatic test_write_read();
    logic [2:0] seen;
    int lat; logic [31:0] ld; logic er, wd;
    // Write 0x10 with per-cycle ready tracking.
    @(negedge CLK);
    dmmWen = 1'b1; dmmaddr = 32'h10; dmmstore = 32'hDEADBEEF;
    @(negedge CLK);
    dmmWen = 1'b0;
    seen[0] = dready;
    @(negedge CLK); seen[1] = dready;
    @(negedge CLK); seen[2] = dready;
    checks++;
    if (seen !== 3'b100) begin
      errors++; $display("FAIL write_ready_timing got %b want 100", seen);
    end
    @(negedge CLK);
    checks++;
    if (dready !== 1'b0 || dmmload !== 32'd0) begin
      errors++; $display("FAIL write_ready_drop got rdy=%b ld=%h want 0/0", dready, dmmload);
    end
    xfer(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, lat, ld, er, wd);
    checks++;
    if (lat !== 2 || wd !== 1'b1 || ld !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_back got lat=%0d d=%b ld=%h want 2/1/deadbeef", lat, wd, ld);
    end
    // Ren+Wen together is a write; dmmload keeps the previous read data.
    xfer(1'b0, 1'b1, 1'b1, 32'h30, 32'h77, lat, ld, er, wd);
    checks++;
    if (lat !== 2 || ld !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rw_is_write got lat=%0d ld=%h want 2/deadbeef", lat, ld);
    end
    xfer(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, lat, ld, er, wd);
    checks++;
    if (ld !== 32'h77) begin
      errors++; $display("FAIL rw_read_back got %h want 00000077", ld);
    end
  endtask

  task automatic test_arbitration();
    logic [7:0] dr, ir;
    logic [31:0] iload, dload;
    int lat; logic [31:0] ld; logic er, wd;
    xfer(1'b0, 1'b0, 1'b1, 32'h40, 32'h12345678, lat, ld, er, wd);
    @(negedge CLK);
    imemRen = 1'b1; imemaddr = 32'h40;
    dmmRen = 1'b1; dmmaddr = 32'h10;
    @(negedge CLK);
    dmmRen = 1'b0;
    iload = 32'hx; dload = 32'hx;
    for (int i = 0; i < 8; i++) begin
      dr[i] = dready; ir[i] = iready;
      if (i == 6) begin
        imemRen = 1'b0; iload = imemload; dload = dmmload;
      end
      if (i < 7) @(negedge CLK);
    end
    checks++;
    if (dr !== 8'b0000_0100) begin
      errors++; $display("FAIL arb_dready got %b want 00000100", dr);
    end
    checks++;
    if (ir !== 8'b0100_0000) begin
      errors++; $display("FAIL arb_iready got %b want 01000000", ir);
    end
    checks++;
    if (iload !== 32'h12345678 || dload !== 32'hDEADBEEF) begin
      errors++; $display("FAIL arb_loads got i=%h d=%h want 12345678/deadbeef", iload, dload);
    end
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] ld; logic er, wd;
    xfer(1'b0, 1'b0, 1'b1, 32'h0000_1004, 32'h1, lat, ld, er, wd);
    xfer(1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h0, lat, ld, er, wd);
    checks++;
    if (ld !== 32'h1) begin
      errors++; $display("FAIL wrap got %h want 00000001", ld);
    end
    xfer(1'b1, 1'b0, 1'b0, 32'h0000_2004, 32'h0, lat, ld, er, wd);
    checks++;
    if (lat !== 2 || wd !== 1'b0 || ld !== 32'h1) begin
      errors++; $display("FAIL wrap_ifetch got lat=%0d d=%b ld=%h want 2/0/00000001", lat, wd, ld);
    end
  endtask

  task automatic test_reset_abort();
    logic any_rdy;
    int lat; logic [31:0] ld; logic er, wd;
    xfer(1'b0, 1'b0, 1'b1, 32'h20, 32'h5, lat, ld, er, wd);
    @(negedge CLK);
    dmmWen = 1'b1; dmmaddr = 32'h20; dmmstore = 32'h99;
    @(negedge CLK);
    dmmWen = 1'b0; nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    checks++;
    if (dmmload !== 32'd0 || imemload !== 32'd0) begin
      errors++; $display("FAIL abort_clear got %h/%h want 0/0", dmmload, imemload);
    end
    any_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      any_rdy |= iready | dready;
      @(negedge CLK);
    end
    checks++;
    if (any_rdy !== 1'b0) begin
      errors++; $display("FAIL abort_no_ready got %b want 0", any_rdy);
    end
    xfer(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, lat, ld, er, wd);
    checks++;
    if (ld !== 32'h5) begin
      errors++; $display("FAIL abort_keeps_word got %h want 00000005", ld);
    end
  endtask

  task automatic test_misalign();
    logic        exp_err;
    logic [31:0] exp_word, exp_mrd;
    int lat; logic [31:0] ld; logic er, wd;
`ifdef MEM_RESP_MISALIGN_CHK_EN
    exp_err = 1'b1; exp_word = 32'h5;        exp_mrd = 32'h0;
`else
    exp_err = 1'b0; exp_word = 32'hAAAA5555; exp_mrd = 32'hAAAA5555;
`endif
    xfer(1'b0, 1'b0, 1'b1, 32'h22, 32'hAAAA5555, lat, ld, er, wd);
    checks++;
    if (lat !== 2 || er !== exp_err) begin
      errors++; $display("FAIL mis_write_err got lat=%0d err=%b want 2/%b", lat, er, exp_err);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL mis_err_drop got %b want 0", err);
    end
    xfer(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, lat, ld, er, wd);
    checks++;
    if (ld !== exp_word || er !== 1'b0) begin
      errors++; $display("FAIL mis_word got %h err=%b want %h/0", ld, er, exp_word);
    end
    xfer(1'b0, 1'b1, 1'b0, 32'h23, 32'h0, lat, ld, er, wd);
    checks++;
    if (ld !== exp_mrd || er !== exp_err) begin
      errors++; $display("FAIL mis_read got %h err=%b want %h/%b", ld, er, exp_mrd, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_arbitration();
    test_wrap();
    test_reset_abort();
    test_misalign();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
